nios_base_sysid_checker: RTL and testbench

- Upstream Avalon-MM master for the system-ID slave.
- After reset, or on request, it reads the ID word (address 0) and the build timestamp (address 1).
- It latches both words, compares them to the build-time expected values and reports pass/fail to boot logic.
- It sits between the boot/reset sequencer and the system-ID slave, and lets hardware refuse to release the CPU on an image mismatch.

---
 rtl/nios_base_sysid_pkg.sv | 20 ++
 rtl/nios_base_sysid_rd_timer.sv | 25 ++
 rtl/nios_base_sysid_checker.sv | 133 +++++++++++++
 tb/tb_nios_base_sysid_checker.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_base_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, slave
// word addresses and the data width of the sysid slave.
package nios_base_sysid_pkg;

  localparam int SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6
  } sysid_state_t;

endpackage

// File: rtl/nios_base_sysid_rd_timer.sv
// Loadable 3-bit down-counter timing the read-latency wait; expired is high
// once the count has reached zero.
module nios_base_sysid_rd_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       expired
);

  logic [2:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign expired = (count == 3'd0);

endmodule

// File: rtl/nios_base_sysid_checker.sv
// Avalon-MM reader that fetches the sysid ID and timestamp words and compares
// them to build-time values. Define SYSID_CHECK_RETRY_EN to retry on mismatch.
module nios_base_sysid_checker
  import nios_base_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID  = 32'd953745243,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS  = 32'd1313854583,
  parameter int                      READ_LATENCY = 0,
  parameter int                      AUTO_START   = 1,
  parameter int                      MAX_RETRIES  = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    sysid_address,
  output logic                    sysid_read,
  input  logic [SYSID_DATA_W-1:0] sysid_readdata,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value,
  output logic                    busy,
  output logic                    done,
  output logic                    id_match,
  output logic                    ts_match,
  output logic [3:0]              retry_count
);

  localparam bit         NO_WAIT   = (READ_LATENCY == 0);
  localparam logic [2:0] WAIT_LOAD = NO_WAIT ? 3'd0 : 3'(READ_LATENCY - 1);

  sysid_state_t state, next_state;
  logic         auto_pend;
  logic         timer_load, timer_expired;
  logic         capture_id, capture_ts;
  logic         id_ok, ts_ok;
  logic         retry_needed, retry_go;
  logic         start_check;
  logic         addr_q;
  logic [3:0]   retry_q;

  nios_base_sysid_rd_timer u_rd_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (WAIT_LOAD),
    .expired  (timer_expired)
  );

  assign id_ok = (id_value == EXPECTED_ID);
  assign ts_ok = (ts_value == EXPECTED_TS);

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    retry_go   = 1'b0;
    case (state)
      IDLE:    if (start || auto_pend) next_state = RD_ID;
      RD_ID: begin
        timer_load = 1'b1;
        next_state = NO_WAIT ? RD_TS : WAIT_ID;
      end
      WAIT_ID: if (timer_expired) next_state = RD_TS;
      RD_TS: begin
        timer_load = 1'b1;
        next_state = NO_WAIT ? CHECK : WAIT_TS;
      end
      WAIT_TS: if (timer_expired) next_state = CHECK;
      CHECK: begin
        retry_go   = retry_needed;
        next_state = retry_needed ? RD_ID : DONE;
      end
      DONE:    if (start) next_state = RD_ID;
      default: next_state = IDLE;
    endcase
  end

  // With zero latency the word is already on the bus during the read strobe.
  assign capture_id  = ((state == RD_ID) && NO_WAIT) || ((state == WAIT_ID) && timer_expired);
  assign capture_ts  = ((state == RD_TS) && NO_WAIT) || ((state == WAIT_TS) && timer_expired);
  assign start_check = ((state == IDLE) || (state == DONE)) && (next_state == RD_ID);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      auto_pend <= (AUTO_START != 0);
      addr_q    <= SYSID_ADDR_ID;
      id_value  <= '0;
      ts_value  <= '0;
      id_match  <= 1'b0;
      ts_match  <= 1'b0;
    end else begin
      state     <= next_state;
      auto_pend <= 1'b0;
      if ((next_state == RD_TS) && (state != RD_TS)) begin
        addr_q <= SYSID_ADDR_TS;
      end else if ((next_state == RD_ID) && (state != RD_ID)) begin
        addr_q <= SYSID_ADDR_ID;
      end
      if (capture_id) id_value <= sysid_readdata;
      if (capture_ts) ts_value <= sysid_readdata;
      if (start_check) begin
        id_match <= 1'b0;
        ts_match <= 1'b0;
      end else if ((state == CHECK) && !retry_go) begin
        id_match <= id_ok;
        ts_match <= ts_ok;
      end
    end
  end

`ifdef SYSID_CHECK_RETRY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_q <= '0;
    end else if (start_check) begin
      retry_q <= '0;
    end else if (retry_go) begin
      retry_q <= retry_q + 4'd1;
    end
  end

  assign retry_needed = !(id_ok && ts_ok) && (retry_q < 4'(MAX_RETRIES));
`else
  assign retry_q      = '0;
  assign retry_needed = 1'b0;
`endif

  assign sysid_address = addr_q;
  assign sysid_read    = (state == RD_ID) || (state == RD_TS);
  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);
  assign retry_count   = retry_q;

endmodule

// File: tb/tb_nios_base_sysid_checker.sv
// Bench for nios_base_sysid_checker: three instances at read latencies 1, 0
// and 7 with modelled sysid slaves, checked every cycle against a schedule model.
module tb_nios_base_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd953745243;
  localparam logic [31:0] EXP_TS = 32'd1313854583;
  localparam logic [31:0] BAD_TS = 32'h0BAD0BAD;
  localparam int          MAXR   = 3;
`ifdef SYSID_CHECK_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  function automatic int lat(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 7);
  endfunction

  // Word the slave returns; the timestamp is wrong until TS pair number ts_fix.
  function automatic logic [31:0] word_for(input logic a, input int pair,
                                           input logic [31:0] id_w, input int fix);
    if (a) return (pair >= fix) ? EXP_TS : BAD_TS;
    return id_w;
  endfunction

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] slave_id;
  int          ts_fix;
  bit          cmp_en = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          fd [3];

  logic        rd [3];
  logic        addr [3];
  logic [31:0] rdata [3];
  logic [31:0] idv [3];
  logic [31:0] tsv [3];
  logic        busy [3];
  logic        done [3];
  logic        idm [3];
  logic        tsm [3];
  logic [3:0]  rc [3];
  int          ts_pairs [3];

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = lat(g);
    logic [31:0] pipe_d [8];
    logic [7:0]  pipe_v;
    int          ts_cnt;

    nios_base_sysid_checker #(
      .EXPECTED_ID  (EXP_ID),
      .EXPECTED_TS  (EXP_TS),
      .READ_LATENCY (L),
      .AUTO_START   (1),
      .MAX_RETRIES  (MAXR)
    ) u_dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .sysid_address  (addr[g]),
      .sysid_read     (rd[g]),
      .sysid_readdata (rdata[g]),
      .id_value       (idv[g]),
      .ts_value       (tsv[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .id_match       (idm[g]),
      .ts_match       (tsm[g]),
      .retry_count    (rc[g])
    );

    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pipe_v <= '0;
        ts_cnt <= 0;
      end else begin
        pipe_v    <= {pipe_v[6:0], rd[g]};
        pipe_d[0] <= word_for(addr[g], ts_cnt + 1, slave_id, ts_fix);
        for (int k = 1; k < 8; k++) pipe_d[k] <= pipe_d[k-1];
        if (rd[g] && addr[g]) ts_cnt <= ts_cnt + 1;
      end
    end

    if (L == 0) begin : g_comb
      assign rdata[g] = rd[g] ? word_for(addr[g], ts_cnt + 1, slave_id, ts_fix) : 32'hDEADBEEF;
    end else begin : g_pipe
      assign rdata[g] = pipe_v[L-1] ? pipe_d[L-1] : 32'hDEADBEEF;
    end

    assign ts_pairs[g] = ts_cnt;
  end

  // Model: an attempt is cycle 0 read ID, L wait cycles, read TS, L wait
  // cycles, one check cycle; words land on the last cycle of each read phase.
  typedef struct {
    bit          run;
    bit          auto_p;
    bit          done;
    bit          idm;
    bit          tsm;
    bit          addr;
    int          t;
    int          retry;
    int          pairs;
    logic [31:0] idv;
    logic [31:0] tsv;
  } mdl_t;

  mdl_t m [3];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{default: 0};
    r.auto_p = 1'b1;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t c, input bit st, input int L,
                                input logic [31:0] id_w, input int fix);
    mdl_t n;
    bit   ok;
    n = c;
    if (!c.run) begin
      if (c.auto_p || st) begin
        n.run = 1; n.t = 0; n.done = 0; n.idm = 0; n.tsm = 0; n.retry = 0; n.addr = 0;
      end
      n.auto_p = 0;
    end else begin
      if (c.t == L) n.idv = id_w;
      if (c.t == 2*L + 1) begin
        n.pairs = c.pairs + 1;
        n.tsv   = (n.pairs >= fix) ? EXP_TS : BAD_TS;
      end
      if (c.t == 2*L + 2) begin
        ok = (c.idv == EXP_ID) && (c.tsv == EXP_TS);
        if (RETRY_ON && !ok && (c.retry < MAXR)) begin
          n.retry = c.retry + 1; n.t = 0; n.addr = 0;
        end else begin
          n.run = 0; n.done = 1;
          n.idm = (c.idv == EXP_ID);
          n.tsm = (c.tsv == EXP_TS);
        end
      end else begin
        n.t = c.t + 1;
        if (n.t == L + 1) n.addr = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 3; g++) m[g] <= mdl_reset();
    end else begin
      for (int g = 0; g < 3; g++) m[g] <= step(m[g], start, lat(g), slave_id, ts_fix);
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("l%0d_read", g), 32'(rd[g]),
            32'(m[g].run && ((m[g].t == 0) || (m[g].t == lat(g) + 1))));
        chk($sformatf("l%0d_addr", g), 32'(addr[g]), 32'(m[g].addr));
        chk($sformatf("l%0d_busy", g), 32'(busy[g]), 32'(m[g].run));
        chk($sformatf("l%0d_done", g), 32'(done[g]), 32'(m[g].done));
        chk($sformatf("l%0d_id_match", g), 32'(idm[g]), 32'(m[g].idm));
        chk($sformatf("l%0d_ts_match", g), 32'(tsm[g]), 32'(m[g].tsm));
        chk($sformatf("l%0d_id_value", g), idv[g], m[g].idv);
        chk($sformatf("l%0d_ts_value", g), tsv[g], m[g].tsv);
        chk($sformatf("l%0d_retry", g), 32'(rc[g]), 32'(m[g].retry));
      end
    end
  end

  // Edge n=1 is the first posedge after the call.
  task automatic wait_done_all(input int budget);
    fd = '{-1, -1, -1};
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock);
      @(negedge clock);
      for (int g = 0; g < 3; g++) if (done[g] && (fd[g] < 0)) fd[g] = n;
      if ((fd[0] >= 0) && (fd[1] >= 0) && (fd[2] >= 0)) break;
    end
    chk("done_within_budget", 32'((fd[0] >= 0) && (fd[1] >= 0) && (fd[2] >= 0)), 32'd1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #3 reset_n = 1'b1;
  endtask

  task automatic hold_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    @(posedge clock);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    slave_id = EXP_ID;
    ts_fix   = 1;
    @(posedge clock);
    cmp_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("reset_done", 32'(done[0]), 32'd0);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_read", 32'(rd[0]), 32'd0);
    chk("reset_id_value", idv[0], 32'd0);

    // Auto-start after reset; edge 1 is the auto-start edge itself.
    release_reset();
    wait_done_all(40);
    chk("lat_rl1", fd[0] - 1, 32'd5);
    chk("lat_rl0", fd[1] - 1, 32'd3);
    chk("lat_rl7", fd[2] - 1, 32'd17);
    chk("pass_id_match", 32'(idm[0]), 32'd1);
    chk("pass_ts_match", 32'(tsm[0]), 32'd1);
    chk("pass_busy", 32'(busy[0]), 32'd0);
    chk("pass_id_value", idv[0], 32'd953745243);
    chk("pass_ts_value_rl7", tsv[2], 32'd1313854583);
    chk("pass_ts_pairs", ts_pairs[0], 32'd1);

    // Wrong ID; start in DONE, then a second start while busy.
    slave_id = 32'h0;
    @(posedge clock);
    #2 start = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
    @(negedge clock);
    chk("restart_done_drop", 32'(done[0]), 32'd0);
    chk("restart_busy", 32'(busy[0]), 32'd1);
    chk("restart_keeps_id", idv[0], 32'd953745243);
    @(posedge clock);
    #2 start = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
    wait_done_all(200);
`ifndef SYSID_CHECK_RETRY_EN
    chk("busy_start_ignored_lat", fd[0], 32'd3);
`endif
    chk("badid_done", 32'(done[0]), 32'd1);
    chk("badid_id_match", 32'(idm[0]), 32'd0);
    chk("badid_ts_match", 32'(tsm[0]), 32'd1);
    chk("badid_id_value", idv[0], 32'd0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("badid_done_holds", 32'(done[0]), 32'd1);

    // Reset while lane 0 sits in WAIT_TS.
    slave_id = EXP_ID;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_clears_done", 32'(done[0]), 32'd0);
    chk("rst_clears_ts_match", 32'(tsm[0]), 32'd0);
    release_reset();
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_id_value", idv[0], 32'd0);
    chk("abort_addr", 32'(addr[0]), 32'd0);
    release_reset();
    wait_done_all(40);
    chk("rerun_lat", fd[0] - 1, 32'd5);
    chk("rerun_id_match", 32'(idm[0]), 32'd1);
    chk("rerun_ts_match", 32'(tsm[0]), 32'd1);

`ifdef SYSID_CHECK_RETRY_EN
    hold_reset();
    ts_fix = 100;
    release_reset();
    wait_done_all(300);
    chk("retry_all_bad_count", 32'(rc[0]), 32'd3);
    chk("retry_all_bad_ts_match", 32'(tsm[0]), 32'd0);
    chk("retry_all_bad_pairs", ts_pairs[0], 32'd4);
    hold_reset();
    ts_fix = 3;
    release_reset();
    wait_done_all(300);
    chk("retry_fix3_count", 32'(rc[0]), 32'd2);
    chk("retry_fix3_id_match", 32'(idm[0]), 32'd1);
    chk("retry_fix3_ts_match", 32'(tsm[0]), 32'd1);
`endif

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
